// File: rtl/counter_pkg.sv
// Shared width, default constants and count type for the signed up/down counter.
// The register lives in counter; the next-value rules live in counter_next.
package counter_pkg;

   localparam int CNT_W     = 10;
   localparam int RESET_VAL = 17;
   localparam int UP_STEP   = 4;
   localparam int DOWN_STEP = 10;
   localparam int MAX_VAL   = 269;
   localparam int MIN_VAL   = -263;
   localparam int SKIP_VAL  = -47;

   typedef logic signed [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/counter_next.sv
// Combinational next count: step by mode, jump over SKIP_VAL, clamp to [MIN_VAL, MAX_VAL].
// Zero latency, no handshake.
module counter_next
   import counter_pkg::*;
#(
   parameter int WIDTH     = CNT_W,
   parameter int UP_STEP   = counter_pkg::UP_STEP,
   parameter int DOWN_STEP = counter_pkg::DOWN_STEP,
   parameter int MAX_VAL   = counter_pkg::MAX_VAL,
   parameter int MIN_VAL   = counter_pkg::MIN_VAL,
   parameter int SKIP_VAL  = counter_pkg::SKIP_VAL
) (
   input  logic signed [WIDTH-1:0] cnt,
   input  logic                    mode,
   output logic signed [WIDTH-1:0] nxt
);

   // Two guard bits so the bound compares see the true sum before truncation.
   localparam int XW = WIDTH + 2;

   localparam logic signed [XW-1:0] UP_X   = XW'(UP_STEP);
   localparam logic signed [XW-1:0] DOWN_X = XW'(DOWN_STEP);
   localparam logic signed [XW-1:0] MAX_X  = XW'(MAX_VAL);
   localparam logic signed [XW-1:0] MIN_X  = XW'(MIN_VAL);
   localparam logic signed [XW-1:0] SKIP_X = XW'(SKIP_VAL);

   logic signed [XW-1:0] cnt_x;
   logic signed [XW-1:0] cand;
   logic signed [XW-1:0] res;

   always_comb begin
      cnt_x = {{2{cnt[WIDTH-1]}}, cnt};
      cand  = mode ? (cnt_x + UP_X) : (cnt_x - DOWN_X);
      res   = cand;
      if (cand == SKIP_X) begin
         res = mode ? (cand + UP_X) : (cand - DOWN_X);
      end else if (cand > MAX_X) begin
         res = MAX_X;
      end else if (cand < MIN_X) begin
         res = MIN_X;
      end
   end

   assign nxt = WIDTH'(res);

endmodule

// File: rtl/counter.sv
// Signed saturating up/down counter that never holds SKIP_VAL; one-cycle update.
// Steps on every clk edge, no enable and no backpressure; synchronous active-low reset.
module counter
   import counter_pkg::*;
#(
   parameter int WIDTH     = CNT_W,
   parameter int RESET_VAL = counter_pkg::RESET_VAL,
   parameter int UP_STEP   = counter_pkg::UP_STEP,
   parameter int DOWN_STEP = counter_pkg::DOWN_STEP,
   parameter int MAX_VAL   = counter_pkg::MAX_VAL,
   parameter int MIN_VAL   = counter_pkg::MIN_VAL,
   parameter int SKIP_VAL  = counter_pkg::SKIP_VAL
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    mode,
   output logic signed [WIDTH-1:0] cnt
);

   logic signed [WIDTH-1:0] nxt;

   counter_next #(
      .WIDTH     (WIDTH),
      .UP_STEP   (UP_STEP),
      .DOWN_STEP (DOWN_STEP),
      .MAX_VAL   (MAX_VAL),
      .MIN_VAL   (MIN_VAL),
      .SKIP_VAL  (SKIP_VAL)
   ) u_next (
      .cnt  (cnt),
      .mode (mode),
      .nxt  (nxt)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= WIDTH'(RESET_VAL);
      end else begin
         cnt <= nxt;
      end
   end

endmodule

// File: tb/tb_counter.sv
// Bench for counter: directed walks through bounds and skip cases, then random mode/reset
// traffic, all compared against an integer model of the counting rules.
module tb_counter;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    mode = 1'b0;
   logic signed [9:0]       cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   counter dut (
      .clk  (clk),
      .rst  (rst),
      .mode (mode),
      .cnt  (cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Integer model: take the step; landing on -47 takes one more step; else clamp.
   function automatic int model_next(input int c, input bit m);
      int cand;
      cand = m ? c + 4 : c - 10;
      if (cand == -47) return m ? -43 : -57;
      if (cand > 269)  return 269;
      if (cand < -263) return -263;
      return cand;
   endfunction

   task automatic tick(input bit r, input bit m);
      int got;
      rst  = r;
      mode = m;
      @(posedge clk);
      #1;
      exp_cnt = r ? model_next(exp_cnt, m) : 17;
      got = cnt;
      check("cnt", got, exp_cnt);
      check("never_skip", int'(got == -47), 0);
      check("in_range", int'(got >= -263 && got <= 269), 1);
   endtask

   initial begin
      int got;

      // Reset then count up into saturation.
      tick(1'b0, 1'b1);
      got = cnt; check("reset_val", got, 17);
      tick(1'b1, 1'b1);
      got = cnt; check("first_up", got, 21);
      for (int i = 1; i < 63; i++) tick(1'b1, 1'b1);
      got = cnt; check("reach_max", got, 269);
      for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
      got = cnt; check("hold_max", got, 269);

      // Down sweep to the lower bound.
      tick(1'b1, 1'b0);
      got = cnt; check("first_down", got, 259);
      for (int i = 1; i < 54; i++) tick(1'b1, 1'b0);
      got = cnt; check("reach_min", got, -263);
      for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
      got = cnt; check("hold_min", got, -263);

      // Up from -263 to -51, then the skip jump to -43.
      for (int i = 0; i < 53; i++) tick(1'b1, 1'b1);
      got = cnt; check("at_m51", got, -51);
      tick(1'b1, 1'b1);
      got = cnt; check("skip_up", got, -43);

      // 17 -> 4 up -> 33 -> 7 down -> -37, then the skip jump to -57.
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
      for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
      got = cnt; check("at_m37", got, -37);
      tick(1'b1, 1'b0);
      got = cnt; check("skip_down", got, -57);

      // Mid-run reset from 149, then resume in both directions.
      tick(1'b0, 1'b1);
      for (int i = 0; i < 33; i++) tick(1'b1, 1'b1);
      got = cnt; check("at_149", got, 149);
      tick(1'b0, 1'b1);
      got = cnt; check("mid_reset", got, 17);
      tick(1'b1, 1'b1);
      got = cnt; check("resume_up", got, 21);
      tick(1'b1, 1'b0);
      got = cnt; check("resume_down", got, 11);

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
